// File: rtl/hs32_alu_seq_pkg.sv
// Shared HS32 ALU opcodes, NZCV flag layout, execute-unit FSM states and
// multiplier build options.
package hs32_alu_seq_pkg;

    localparam logic [3:0] HS32A_ADD  = 4'h0;
    localparam logic [3:0] HS32A_ADC  = 4'h1;
    localparam logic [3:0] HS32A_SUB  = 4'h2;
    localparam logic [3:0] HS32A_SBC  = 4'h3;
    localparam logic [3:0] HS32A_AND  = 4'h4;
    localparam logic [3:0] HS32A_OR   = 4'h5;
    localparam logic [3:0] HS32A_XOR  = 4'h6;
    localparam logic [3:0] HS32A_BIC  = 4'h7;
    localparam logic [3:0] HS32A_MOV  = 4'h8;
    localparam logic [3:0] HS32A_MOV2 = 4'h9;
    localparam logic [3:0] HS32A_MUL  = 4'hA;

    localparam int MUL_NONE = 0;
    localparam int MUL_ITER = 1;
    localparam int MUL_COMB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } hs32_state_e;

    // Bit 3 = N ... bit 0 = V.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } hs32_fl_t;

endpackage

// File: rtl/hs32_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle. product is the
// accumulator including the current step, so it is final in the done cycle.
module hs32_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] a_sh_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic [2*WIDTH-1:0] addend;

    // a is pre-shifted and b consumed LSB-first, so step i adds a<<i when b[i] is set.
    assign addend  = b_reg[0] ? a_sh_reg : '0;
    assign product = acc_reg + addend;
    assign done    = busy_reg && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg <= '0;
            acc_reg  <= '0;
            b_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            a_sh_reg <= {{WIDTH{1'b0}}, a};
            acc_reg  <= '0;
            b_reg    <= b;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            acc_reg  <= product;
            a_sh_reg <= a_sh_reg << 1;
            b_reg    <= b_reg >> 1;
            if (done) begin
                cnt_reg  <= '0;
                busy_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs32_alu_seq.sv
// HS32 execute-stage ALU with valid/ready handshake, full NZCV generation and
// a build-time selectable multiplier (none, iterative, single-cycle).
module hs32_alu_seq
    import hs32_alu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_fl,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_r,
    output logic [3:0]       o_fl
);

    localparam int  M    = WIDTH - 1;
    localparam bit  ITER = (MUL_MODE == MUL_ITER);
    localparam bit  COMB = (MUL_MODE == MUL_COMB);

    hs32_state_e        state_reg;
    hs32_fl_t           fl_hold_reg;
    hs32_fl_t           fl_in;
    hs32_fl_t           fl_next;
    hs32_fl_t           iter_fl;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH-1:0]   res_next;
    logic [WIDTH-1:0]   iter_r;
    logic               c_next;
    logic               v_next;
    logic [2*WIDTH-1:0] mul_comb;
    logic [2*WIDTH-1:0] iter_prod;
    logic               iter_done;
    logic               accept;

    assign o_ready = (state_reg == ST_IDLE);
    assign o_valid = (state_reg == ST_DONE);
    assign accept  = i_valid && o_ready;
    assign fl_in   = hs32_fl_t'(i_fl);

    generate
        if (ITER) begin : g_mul_iter
            hs32_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (accept && (i_op == HS32A_MUL)),
                .a       (i_a),
                .b       (i_b),
                .done    (iter_done),
                .product (iter_prod)
            );
        end else begin : g_no_iter
            assign iter_done = 1'b0;
            assign iter_prod = '0;
        end

        if (COMB) begin : g_mul_comb
            assign mul_comb = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
        end else begin : g_no_comb
            assign mul_comb = '0;
        end
    endgenerate

    always_comb begin
        sum_w  = {1'b0, i_a} + {1'b0, i_b}
               + {{WIDTH{1'b0}}, (i_op == HS32A_ADC) & fl_in.c};
        diff_w = {1'b0, i_a} - {1'b0, i_b}
               - {{WIDTH{1'b0}}, (i_op == HS32A_SBC) & fl_in.c};
        // MOV, undefined ops and (without a single-cycle multiplier) MUL fall through to b.
        res_next = i_b;
        c_next   = fl_in.c;
        v_next   = fl_in.v;
        case (i_op)
            HS32A_ADD, HS32A_ADC: begin
                res_next = sum_w[WIDTH-1:0];
                c_next   = sum_w[WIDTH];
                v_next   = (i_a[M] == i_b[M]) && (sum_w[M] != i_a[M]);
            end
            HS32A_SUB, HS32A_SBC: begin
                res_next = diff_w[WIDTH-1:0];
                c_next   = diff_w[WIDTH];
                v_next   = (i_a[M] != i_b[M]) && (diff_w[M] != i_a[M]);
            end
            HS32A_AND:  res_next = i_a & i_b;
            HS32A_OR:   res_next = i_a | i_b;
            HS32A_XOR:  res_next = i_a ^ i_b;
            HS32A_BIC:  res_next = i_a & ~i_b;
            HS32A_MOV2: res_next = i_a;
            HS32A_MUL: begin
                if (COMB) begin
                    res_next = mul_comb[WIDTH-1:0];
                    c_next   = |mul_comb[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
        fl_next = '{n: res_next[M], z: (res_next == '0), c: c_next, v: v_next};

        iter_r  = iter_prod[WIDTH-1:0];
        iter_fl = '{n: iter_r[M], z: (iter_r == '0),
                    c: |iter_prod[2*WIDTH-1:WIDTH], v: fl_hold_reg.v};
    end

    // Operands for the iterative path are captured inside the multiplier;
    // only the incoming V survives here for the final flag word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            fl_hold_reg <= '0;
            o_r         <= '0;
            o_fl        <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        fl_hold_reg <= fl_in;
                        if (ITER && (i_op == HS32A_MUL)) begin
                            state_reg <= ST_MUL;
                        end else begin
                            state_reg <= ST_DONE;
                            o_r       <= res_next;
                            o_fl      <= fl_next;
                        end
                    end
                end
                ST_MUL: begin
                    if (iter_done) begin
                        state_reg <= ST_DONE;
                        o_r       <= iter_r;
                        o_fl      <= iter_fl;
                    end
                end
                ST_DONE: begin
                    if (i_ready) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_alu_seq.sv
// Directed bench for hs32_alu_seq: four builds (32-bit iterative/comb/no
// multiplier, 8-bit iterative) checked against hand-computed results.
module tb_hs32_alu_seq;
    import hs32_alu_seq_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             i_ready;
    logic [3:0]       op;
    logic [3:0]       fl;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       valid;
    logic [3:0]       rdy;
    logic [3:0]       vo;
    logic [3:0][31:0] r_o;
    logic [3:0][3:0]  fl_o;
    logic [7:0]       r8;

    int n_tests = 0;
    int n_fail  = 0;

    assign r_o[3] = {24'h0, r8};

    hs32_alu_seq #(.WIDTH(32), .MUL_MODE(1)) u_iter (
        .clk(clk), .rst_n(rst_n), .i_valid(valid[0]), .o_ready(rdy[0]),
        .i_op(op), .i_a(a), .i_b(b), .i_fl(fl), .o_valid(vo[0]),
        .i_ready(i_ready), .o_r(r_o[0]), .o_fl(fl_o[0]));

    hs32_alu_seq #(.WIDTH(32), .MUL_MODE(2)) u_comb (
        .clk(clk), .rst_n(rst_n), .i_valid(valid[1]), .o_ready(rdy[1]),
        .i_op(op), .i_a(a), .i_b(b), .i_fl(fl), .o_valid(vo[1]),
        .i_ready(i_ready), .o_r(r_o[1]), .o_fl(fl_o[1]));

    hs32_alu_seq #(.WIDTH(32), .MUL_MODE(0)) u_none (
        .clk(clk), .rst_n(rst_n), .i_valid(valid[2]), .o_ready(rdy[2]),
        .i_op(op), .i_a(a), .i_b(b), .i_fl(fl), .o_valid(vo[2]),
        .i_ready(i_ready), .o_r(r_o[2]), .o_fl(fl_o[2]));

    hs32_alu_seq #(.WIDTH(8), .MUL_MODE(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .i_valid(valid[3]), .o_ready(rdy[3]),
        .i_op(op), .i_a(a[7:0]), .i_b(b[7:0]), .i_fl(fl), .o_valid(vo[3]),
        .i_ready(i_ready), .o_r(r8), .o_fl(fl_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op to DUT d, check latency/result/flags, hold i_ready low for
    // `hold` cycles checking stability, then acknowledge.
    task automatic run_op(input int d, input string tag, input logic [3:0] t_op,
                          input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [3:0] t_fl, input logic [31:0] exp_r,
                          input logic [3:0] exp_fl, input int exp_lat, input int hold);
        int lat;
        op = t_op; a = t_a; b = t_b; fl = t_fl;
        valid[d] = 1'b1;
        @(posedge clk); #1;
        valid[d] = 1'b0;
        // Scramble inputs: a busy unit must ignore them.
        op = 4'hF; a = 32'hDEADBEEF; b = 32'h12345678; fl = 4'hF;
        lat = 1;
        while (!vo[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_r"}, 64'(r_o[d]), 64'(exp_r));
        check({tag, "_fl"}, 64'(fl_o[d]), 64'(exp_fl));
        $display("[TB] %s dut=%0d op=%0h a=%0h b=%0h fl=%b -> r=%0h nzcv=%b lat=%0d",
                 tag, d, t_op, t_a, t_b, t_fl, r_o[d], fl_o[d], lat);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_r"}, 64'(r_o[d]), 64'(exp_r));
            check({tag, "_hold_fl"}, 64'(fl_o[d]), 64'(exp_fl));
            check({tag, "_hold_vo"}, 64'(vo[d]), 64'd1);
            check({tag, "_hold_rdy"}, 64'(rdy[d]), 64'd0);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({tag, "_rdy_after"}, 64'(rdy[d]), 64'd1);
        check({tag, "_vo_after"}, 64'(vo[d]), 64'd0);
    endtask

    initial begin
        int vo_seen;
        rst_n = 1'b0; i_ready = 1'b0; valid = '0;
        op = '0; a = '0; b = '0; fl = '0;
        #22;
        for (int d = 0; d < 4; d++) begin
            check("rst_rdy", 64'(rdy[d]), 64'd1);
            check("rst_vo", 64'(vo[d]), 64'd0);
            check("rst_r", 64'(r_o[d]), 64'd0);
            check("rst_fl", 64'(fl_o[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, "add_ovf", HS32A_ADD, 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 4'b1001, 1, 0);
        run_op(0, "sub_brw", HS32A_SUB, 32'h0, 32'h1, 4'b0000, 32'hFFFFFFFF, 4'b1010, 1, 0);
        run_op(0, "sbc",     HS32A_SBC, 32'h5, 32'h5, 4'b0010, 32'hFFFFFFFF, 4'b1010, 1, 0);
        run_op(0, "adc",     HS32A_ADC, 32'hFFFFFFFF, 32'h0, 4'b0010, 32'h0, 4'b0110, 1, 0);
        run_op(0, "and_pass", HS32A_AND, 32'hF0, 32'h0F, 4'b0011, 32'h0, 4'b0111, 1, 0);
        run_op(0, "bic",     HS32A_BIC, 32'hFF, 32'h0F, 4'b0000, 32'hF0, 4'b0000, 1, 0);
        run_op(0, "xor",     HS32A_XOR, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 32'hF0F0F0F0, 4'b1000, 1, 0);
        run_op(0, "mov2",    HS32A_MOV2, 32'h80000000, 32'h5, 4'b0000, 32'h80000000, 4'b1000, 1, 0);
        run_op(0, "undef",   4'hF, 32'h1, 32'h2, 4'b1111, 32'h2, 4'b0011, 1, 0);
        run_op(0, "mul_it",  HS32A_MUL, 32'h10000, 32'h10000, 4'b0000, 32'h0, 4'b0110, 33, 0);
        run_op(0, "mul_it2", HS32A_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 32'h1, 4'b0011, 33, 0);
        run_op(1, "mul_cb",  HS32A_MUL, 32'h10000, 32'h10000, 4'b0000, 32'h0, 4'b0110, 1, 0);
        run_op(2, "mul_no",  HS32A_MUL, 32'h3, 32'h7, 4'b0011, 32'h7, 4'b0011, 1, 0);
        run_op(3, "w8_add",  HS32A_ADD, 32'hFF, 32'h01, 4'b0000, 32'h0, 4'b0110, 1, 0);
        run_op(3, "w8_mul",  HS32A_MUL, 32'h10, 32'h10, 4'b0000, 32'h0, 4'b0110, 9, 0);
        run_op(0, "bp",      HS32A_ADD, 32'h1, 32'h2, 4'b0000, 32'h3, 4'b0000, 1, 5);

        // Reset pulsed mid-multiply: unit returns to idle, result never appears.
        op = HS32A_MUL; a = 32'h3; b = 32'h5; fl = 4'b0000;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_busy", 64'(rdy[0]), 64'd0);
        rst_n = 1'b0;
        #2;
        check("midrst_rdy", 64'(rdy[0]), 64'd1);
        check("midrst_vo", 64'(vo[0]), 64'd0);
        rst_n = 1'b1;
        vo_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (vo[0]) vo_seen++;
        end
        check("midrst_novalid", 64'(vo_seen), 64'd0);
        run_op(0, "post_rst", HS32A_MUL, 32'h3, 32'h5, 4'b0000, 32'hF, 4'b0000, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
